fetch_unit: RTL and testbench

- Program counter and fetch sequencer sitting directly upstream of the control decoder.
- Drives the instruction ROM address (ProgCtr). The ROM returns the 9-bit instruction to the decoder.
- Consumes the decoder's BranchEn and the ALU's Taken flag to select the next PC.
- Sequences program start and halt, and counts executed cycles for benchmarking.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_branch_lut.sv | 36 +++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: sequencer states and the
// fixed branch target table.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int kPcW      = 10;
    localparam int kLutDepth = 16;

    // Entries 0..2 are fixed by the program ABI; the rest are program-specific.
    localparam logic [kPcW-1:0] kBranchLut [kLutDepth] = '{
        10'd0,   10'd16,  10'd40,  10'd64,
        10'd100, 10'd128, 10'd200, 10'd256,
        10'd300, 10'd384, 10'd512, 10'd640,
        10'd768, 10'd896, 10'd1000, 10'd1023
    };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch target ROM: maps a 4-bit instruction field to a
// PC target taken from the package table.
module branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4
) (
    input  logic [LUT_IDX_W-1:0] i_idx,
    output logic [PC_W-1:0]      o_target
);

    always_comb begin
        o_target = '0;
        case (i_idx)
            LUT_IDX_W'(0):  o_target = PC_W'(kBranchLut[0]);
            LUT_IDX_W'(1):  o_target = PC_W'(kBranchLut[1]);
            LUT_IDX_W'(2):  o_target = PC_W'(kBranchLut[2]);
            LUT_IDX_W'(3):  o_target = PC_W'(kBranchLut[3]);
            LUT_IDX_W'(4):  o_target = PC_W'(kBranchLut[4]);
            LUT_IDX_W'(5):  o_target = PC_W'(kBranchLut[5]);
            LUT_IDX_W'(6):  o_target = PC_W'(kBranchLut[6]);
            LUT_IDX_W'(7):  o_target = PC_W'(kBranchLut[7]);
            LUT_IDX_W'(8):  o_target = PC_W'(kBranchLut[8]);
            LUT_IDX_W'(9):  o_target = PC_W'(kBranchLut[9]);
            LUT_IDX_W'(10): o_target = PC_W'(kBranchLut[10]);
            LUT_IDX_W'(11): o_target = PC_W'(kBranchLut[11]);
            LUT_IDX_W'(12): o_target = PC_W'(kBranchLut[12]);
            LUT_IDX_W'(13): o_target = PC_W'(kBranchLut[13]);
            LUT_IDX_W'(14): o_target = PC_W'(kBranchLut[14]);
            LUT_IDX_W'(15): o_target = PC_W'(kBranchLut[15]);
            default:        o_target = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: start/halt control, next-PC
// selection (restart, stall, halt, branch, increment) and a RUN cycle counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [PC_W-1:0]      StartAddr,
    input  logic                 Stall,
    input  logic                 BranchEn,
    input  logic                 Taken,
    input  logic [LUT_IDX_W-1:0] BranchIdx,
    input  logic                 Halt,
    output logic [PC_W-1:0]      ProgCtr,
    output logic                 Running,
    output logic                 Done,
    output logic [CNT_W-1:0]     CycleCt
);

    fetch_state_t         r_state;
    logic [PC_W-1:0]      r_pc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;

    fetch_state_t         w_state_nxt;
    logic [PC_W-1:0]      w_pc_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_done_nxt;
    logic [PC_W-1:0]      w_branch_tgt;

    // Benchmark counter sticks at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_branch_lut (
        .i_idx    (BranchIdx),
        .o_target (w_branch_tgt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = StartAddr;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (Start) begin
                    w_pc_nxt  = StartAddr;
                    w_cnt_nxt = '0;
                end else begin
                    // Stall and Halt cycles still count as RUN time.
                    w_cnt_nxt = sat_inc(r_cnt);
                    if (!Stall) begin
                        if (Halt) begin
                            w_state_nxt = HALTED;
                            w_done_nxt  = 1'b1;
                        end else if (BranchEn && Taken) begin
                            w_pc_nxt = w_branch_tgt;
                        end else begin
                            w_pc_nxt = r_pc + PC_W'(1);
                        end
                    end
                end
            end
            HALTED: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = StartAddr;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ProgCtr = r_pc;
    assign Running = (r_state == RUN);
    assign Done    = r_done;
    assign CycleCt = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model pushes expected outputs
// to a queue per driven cycle, popped and checked after each rising edge.
module tb_fetch_unit;

    localparam int PC_W      = 10;
    localparam int LUT_IDX_W = 4;
    localparam int CNT_W     = 6;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int PC_MOD    = 1 << PC_W;

    logic                 CLK = 1'b0;
    logic                 Reset_n;
    logic                 Start;
    logic [PC_W-1:0]      StartAddr;
    logic                 Stall;
    logic                 BranchEn;
    logic                 Taken;
    logic [LUT_IDX_W-1:0] BranchIdx;
    logic                 Halt;
    logic [PC_W-1:0]      ProgCtr;
    logic                 Running;
    logic                 Done;
    logic [CNT_W-1:0]     CycleCt;

    fetch_unit #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Stall     (Stall),
        .BranchEn  (BranchEn),
        .Taken     (Taken),
        .BranchIdx (BranchIdx),
        .Halt      (Halt),
        .ProgCtr   (ProgCtr),
        .Running   (Running),
        .Done      (Done),
        .CycleCt   (CycleCt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        int running;
        int done;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model state: 0 idle, 1 run, 2 halted.
    int m_state = 0;
    int m_pc    = 0;
    int m_cnt   = 0;
    int m_done  = 0;
    int lut_tb [16] = '{0, 16, 40, 64, 100, 128, 200, 256,
                        300, 384, 512, 640, 768, 896, 1000, 1023};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".pc"},      32'(ProgCtr), e.pc);
        chk({tag, ".running"}, 32'(Running), e.running);
        chk({tag, ".done"},    32'(Done),    e.done);
        chk({tag, ".cnt"},     32'(CycleCt), e.cnt);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_cnt   = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input bit st, input int sa, input bit stl,
                              input bit br, input bit tk, input int idx, input bit hlt);
        if (m_state == 0) begin
            if (st) begin m_state = 1; m_pc = sa; m_cnt = 0; end
        end else if (m_state == 1) begin
            if (st) begin
                m_pc = sa; m_cnt = 0;
            end else begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (stl) begin
                    // hold
                end else if (hlt) begin
                    m_state = 2; m_done = 1;
                end else if (br && tk) begin
                    m_pc = lut_tb[idx];
                end else begin
                    m_pc = (m_pc + 1) % PC_MOD;
                end
            end
        end else begin
            if (st) begin m_state = 1; m_pc = sa; m_cnt = 0; m_done = 0; end
        end
    endtask

    task automatic cycle(input string tag, input bit st, input int sa, input bit stl,
                         input bit br, input bit tk, input int idx, input bit hlt);
        exp_t e;
        @(negedge CLK);
        Start     = st;
        StartAddr = PC_W'(sa);
        Stall     = stl;
        BranchEn  = br;
        Taken     = tk;
        BranchIdx = LUT_IDX_W'(idx);
        Halt      = hlt;
        model_step(st, sa, stl, br, tk, idx, hlt);
        e = '{m_pc, (m_state == 1) ? 1 : 0, m_done, m_cnt};
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk_out(tag, e);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t z;
        z = '{0, 0, 0, 0};
        Reset_n = 1'b0; Start = 0; StartAddr = '0; Stall = 0;
        BranchEn = 0; Taken = 0; BranchIdx = '0; Halt = 0;
        #12;
        chk_out("reset", z);
        @(negedge CLK);
        Reset_n = 1'b1;

        // IDLE ignores everything but Start
        cycle("idle_ign", 0, 0, 1, 1, 1, 2, 1);
        cycle("idle_ign2", 0, 0, 0, 1, 1, 5, 1);

        cycle("start5", 1, 5, 0, 0, 0, 0, 0);
        run("seq5", 3);

        // branch taken / not taken / Taken without BranchEn
        cycle("start20", 1, 20, 0, 0, 0, 0, 0);
        cycle("br_taken", 0, 0, 0, 1, 1, 2, 0);
        cycle("start20b", 1, 20, 0, 0, 0, 0, 0);
        cycle("br_nottaken", 0, 0, 0, 1, 0, 2, 0);
        cycle("tk_only", 0, 0, 0, 0, 1, 1, 0);
        cycle("br_idx15", 0, 0, 0, 1, 1, 15, 0);
        cycle("br_idx1", 0, 0, 0, 1, 1, 1, 0);

        // Start beats Stall in RUN
        cycle("start_vs_stall", 1, 30, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("stall_halt", 0, 0, 1, 1, 1, 2, 1);
        cycle("halt", 0, 0, 0, 0, 0, 0, 1);
        cycle("halted_ign", 0, 0, 1, 1, 1, 2, 1);
        run("halted_hold", 2);

        // PC wrap
        cycle("start1022", 1, 1022, 0, 0, 0, 0, 0);
        run("wrap", 3);

        // halt after 7 RUN cycles, then restart from HALTED
        cycle("start100", 1, 100, 0, 0, 0, 0, 0);
        run("run6", 6);
        cycle("halt7", 0, 0, 0, 0, 0, 0, 1);
        run("hold7", 2);
        cycle("restart0", 1, 0, 0, 0, 0, 0, 0);

        // counter saturation
        run("sat", CNT_MAX + 6);

        // asynchronous reset between edges at PC=12
        cycle("start10", 1, 10, 0, 0, 0, 0, 0);
        run("to12", 2);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk_out("async_rst", z);
        chk("sb_empty", 32'(sb.size()), 0);
        @(negedge CLK);
        Reset_n = 1'b1;
        cycle("post_rst", 0, 0, 0, 0, 0, 0, 0);
        cycle("post_rst_start", 1, 7, 0, 0, 0, 0, 0);
        run("post_rst_run", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
